// File: rtl/sym_vn_lut_loader_pkg.sv
// Shared definitions for the symmetric VN IB LUT loader: default sizes,
// page/frame width derivations, FSM state encoding and the bit offsets of
// the two bank fields inside an entry pair.
package sym_vn_lut_loader_pkg;

  localparam int DEF_QUAN_SIZE       = 3;
  localparam int DEF_ENTRY_ADDR      = 5;
  localparam int DEF_MULTI_FRAME_NUM = 2;

  // Frame offset width; at least one bit so the port never collapses.
  function automatic int frame_w_of(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

  // Page address width: whatever is left of the LUT address after the frame offset.
  function automatic int page_w_of(input int entry_addr, input int frames);
    return entry_addr - ((frames > 1) ? $clog2(frames) : 0);
  endfunction

  localparam int DEF_PAGE_W  = page_w_of(DEF_ENTRY_ADDR, DEF_MULTI_FRAME_NUM);
  localparam int DEF_FRAME_W = frame_w_of(DEF_MULTI_FRAME_NUM);

  // Entry pair layout: bank0 word in the low half, bank1 word directly above.
  localparam int ENTRY_BANK0_LSB = 0;

  function automatic int entry_bank1_lsb(input int quan);
    return ENTRY_BANK0_LSB + quan;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/sym_vn_lut_loader_if.sv
// Entry stream (valid/ready) plus the LUT write bus driven by the loader.
// slave: the loader side. master: the source/observer side.
interface sym_vn_lut_loader_if
  import sym_vn_lut_loader_pkg::*;
#(
  parameter int QUAN_SIZE = DEF_QUAN_SIZE,
  parameter int PAGE_W    = DEF_PAGE_W,
  parameter int FRAME_W   = DEF_FRAME_W
) ();

  logic                   in_valid;
  logic [2*QUAN_SIZE-1:0] in_data;
  logic                   in_ready;
  logic                   we;
  logic [PAGE_W-1:0]      page_write_addr;
  logic [FRAME_W-1:0]     write_addr_offset;
  logic [QUAN_SIZE-1:0]   lut_in_bank0;
  logic [QUAN_SIZE-1:0]   lut_in_bank1;

  modport master (
    output in_valid, in_data,
    input  in_ready, we, page_write_addr, write_addr_offset, lut_in_bank0, lut_in_bank1
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, page_write_addr, write_addr_offset, lut_in_bank0, lut_in_bank1
  );

endinterface

// File: rtl/sym_vn_lut_wr_cnt.sv
// Page counter for the LUT loader: synchronous clear, increment, and a
// terminal-count flag raised while the counter sits on the last page.
// Incrementing past the last page wraps back to 0.
module sym_vn_lut_wr_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_reg;

  // Clear has priority over increment so a new load always starts at page 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = &count_reg;

endmodule

// File: rtl/sym_vn_lut_loader.sv
// Write-side producer for the dual-bank symmetric VN IB LUT wrapper.
// Takes a valid/ready stream of entry pairs and writes one full frame
// (2^PAGE_W pages) into both banks, one registered write per handshake.
// Optional checksum accumulator: define SYM_VN_LUT_LOADER_CKSUM_EN.
module sym_vn_lut_loader
  import sym_vn_lut_loader_pkg::*;
#(
  parameter int QUAN_SIZE       = DEF_QUAN_SIZE,
  parameter int ENTRY_ADDR      = DEF_ENTRY_ADDR,
  parameter int MULTI_FRAME_NUM = DEF_MULTI_FRAME_NUM,
  localparam int PAGE_W         = page_w_of(ENTRY_ADDR, MULTI_FRAME_NUM),
  localparam int FRAME_W        = frame_w_of(MULTI_FRAME_NUM)
) (
  input  logic                   write_clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic [FRAME_W-1:0]     load_frame,
  output logic                   busy,
  output logic                   load_done,
  output logic [2*QUAN_SIZE-1:0] cksum,
  sym_vn_lut_loader_if.slave     bus
);

  localparam int BANK1_LSB = entry_bank1_lsb(QUAN_SIZE);

  load_state_t          state_reg;
  logic [FRAME_W-1:0]   frame_reg;
  logic                 in_ready_reg;
  logic                 we_reg;
  logic [PAGE_W-1:0]    page_addr_reg;
  logic [FRAME_W-1:0]   offset_reg;
  logic [QUAN_SIZE-1:0] bank0_reg;
  logic [QUAN_SIZE-1:0] bank1_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic                 start_accept;
  logic                 handshake;
  logic [PAGE_W-1:0]    page_count;
  logic                 page_last;

  assign start_accept = (state_reg == ST_IDLE) && load_start;
  assign handshake    = in_ready_reg && bus.in_valid;

  sym_vn_lut_wr_cnt #(
    .W (PAGE_W)
  ) u_wr_cnt (
    .clk   (write_clk),
    .srst  (rst),
    .clr   (start_accept),
    .inc   (handshake),
    .count (page_count),
    .tc    (page_last)
  );

  // Load sequencer with registered LUT write bus, ready, busy and done.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      frame_reg     <= '0;
      in_ready_reg  <= 1'b0;
      we_reg        <= 1'b0;
      page_addr_reg <= '0;
      offset_reg    <= '0;
      bank0_reg     <= '0;
      bank1_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // busy stays up through the load_done cycle and falls after it
          busy_reg <= load_start;
          if (load_start) begin
            state_reg    <= ST_LOAD;
            frame_reg    <= load_frame;
            in_ready_reg <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            we_reg        <= 1'b1;
            page_addr_reg <= page_count;
            offset_reg    <= frame_reg;
            bank0_reg     <= bus.in_data[ENTRY_BANK0_LSB +: QUAN_SIZE];
            bank1_reg     <= bus.in_data[BANK1_LSB +: QUAN_SIZE];
            if (page_last) begin
              in_ready_reg <= 1'b0;
              state_reg    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg    <= ST_IDLE;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYM_VN_LUT_LOADER_CKSUM_EN
  logic [2*QUAN_SIZE-1:0] cksum_reg;

  // XOR of every entry pair accepted since the last start.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      cksum_reg <= '0;
    end else if (start_accept) begin
      cksum_reg <= '0;
    end else if (handshake) begin
      cksum_reg <= cksum_reg ^ bus.in_data;
    end
  end

  assign cksum = cksum_reg;
`else
  assign cksum = '0;
`endif

  assign bus.in_ready          = in_ready_reg;
  assign bus.we                = we_reg;
  assign bus.page_write_addr   = page_addr_reg;
  assign bus.write_addr_offset = offset_reg;
  assign bus.lut_in_bank0      = bank0_reg;
  assign bus.lut_in_bank1      = bank1_reg;
  assign busy                  = busy_reg;
  assign load_done             = done_reg;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Bench for sym_vn_lut_loader: directed table for a back-to-back load,
// hand-written corner sequences, and a randomized run, all checked against
// a transaction-level reference model kept in this file.
module tb_sym_vn_lut_loader;

  logic       write_clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [0:0] load_frame;
  logic       busy;
  logic       load_done;
  logic [5:0] cksum;

  sym_vn_lut_loader_if bus ();

  sym_vn_lut_loader dut (
    .write_clk  (write_clk),
    .rst        (rst),
    .load_start (load_start),
    .load_frame (load_frame),
    .busy       (busy),
    .load_done  (load_done),
    .cksum      (cksum),
    .bus        (bus)
  );

  always #5 write_clk = ~write_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: expected outputs after the most recent edge.
  bit       e_ready, e_we, e_busy, e_done, e_off;
  bit [3:0] e_page;
  bit [2:0] e_b0, e_b1;
  bit [5:0] m_ck;
  int       m_n;      // entries accepted in the current load
  bit       m_frame;
  bit       m_fin;    // final entry accepted on the previous edge

  // Observation counters
  int       cnt_we, cnt_done, first_page;
  bit [5:0] ck_at_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_ready = 0; e_we = 0; e_busy = 0; e_done = 0; e_off = 0;
    e_page = 0; e_b0 = 0; e_b1 = 0; m_ck = 0; m_n = 0; m_frame = 0; m_fin = 0;
  endtask

  // One edge of the reference model, applied to the inputs that were present.
  task automatic model_step(input bit r, input bit s, input bit f, input bit v, input bit [5:0] d);
    bit idle, hs;
    idle = !e_busy || e_done;
    hs   = e_ready && v;
    if (r) begin
      model_reset();
    end else begin
      e_done = m_fin;
      m_fin  = 0;
      e_we   = hs;
      if (hs) begin
        e_page = m_n[3:0];
        e_off  = m_frame;
        e_b0   = d[2:0];
        e_b1   = d[5:3];
        m_ck   = m_ck ^ d;
        m_n++;
        if (m_n == 16) begin
          e_ready = 0;
          m_fin   = 1;
        end
      end
      if (idle) begin
        e_busy = s;
        if (s) begin
          e_ready = 1;
          m_n     = 0;
          m_frame = f;
          m_ck    = 0;
        end
      end
    end
  endtask

  // Drive inputs, clock once, advance the model and compare every output.
  task automatic cycle(input bit r, input bit s, input bit f, input bit v, input bit [5:0] d);
    bit [5:0] exp_ck;
    rst = r; load_start = s; load_frame = f; bus.in_valid = v; bus.in_data = d;
    @(posedge write_clk);
    #1;
    model_step(r, s, f, v, d);
`ifdef SYM_VN_LUT_LOADER_CKSUM_EN
    exp_ck = m_ck;
`else
    exp_ck = 6'h00;
`endif
    chk("in_ready", bus.in_ready, e_ready);
    chk("we", bus.we, e_we);
    chk("busy", busy, e_busy);
    chk("load_done", load_done, e_done);
    chk("page_write_addr", bus.page_write_addr, e_page);
    chk("write_addr_offset", bus.write_addr_offset, e_off);
    chk("lut_in_bank0", bus.lut_in_bank0, e_b0);
    chk("lut_in_bank1", bus.lut_in_bank1, e_b1);
    chk("cksum", cksum, exp_ck);
    if (bus.we === 1'b1) begin
      if (cnt_we == 0) first_page = int'(bus.page_write_addr);
      cnt_we++;
    end
    if (load_done === 1'b1) begin
      cnt_done++;
      ck_at_done = cksum;
    end
  endtask

  task automatic clear_obs();
    cnt_we = 0; cnt_done = 0; first_page = -1; ck_at_done = 6'h00;
  endtask

  typedef struct {
    bit       start;
    bit       frame;
    bit       valid;
    bit [5:0] data;
    bit       x_ready;
    bit       x_we;
    bit [3:0] x_page;
    bit       x_off;
    bit [2:0] x_b0;
    bit [2:0] x_b1;
    bit       x_busy;
    bit       x_done;
  } vec_t;

  vec_t tbl[20];

  // Feed one load of 16 entries; entry 0 gets 'first', the rest 'rest'.
  task automatic run_load(input bit f, input bit [5:0] first, input bit [5:0] rest,
                          input bit bubble, input string tag);
    int budget;
    bit [5:0] d;
    bit v;
    clear_obs();
    cycle(0, 1, f, 0, 6'h00);
    budget = 0;
    while (cnt_done == 0 && budget < 200) begin
      d = (m_n == 0) ? first : rest;
      v = bubble ? ((budget % 2) == 0) : 1'b1;
      cycle(0, 0, f, v, d);
      budget++;
    end
    chk({tag, "_done_seen"}, cnt_done, 1);
    chk({tag, "_we_count"}, cnt_we, 16);
    chk({tag, "_first_page"}, first_page, 0);
    cycle(0, 0, 0, 0, 6'h00);
  endtask

  initial begin
    int budget, bad_off;
    bit [5:0] exp_ck;
    model_reset();
    clear_obs();
    rst = 1; load_start = 0; load_frame = 0; bus.in_valid = 0; bus.in_data = 0;

    // Reset, then idle with in_valid high and no start
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 6'h2A);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 6'($urandom));
    chk("idle_we_count", cnt_we, 0);
    chk("idle_done_count", cnt_done, 0);

    // Directed back-to-back load into frame 1, data k = 0..15
    for (int i = 0; i < 20; i++) begin
      tbl[i].start = (i == 0);
      tbl[i].frame = 1'b1;
      tbl[i].valid = 1'b1;
      tbl[i].data  = (i >= 1 && i <= 16) ? 6'(i - 1) : 6'h00;
      tbl[i].x_we  = (i >= 1 && i <= 16);
      tbl[i].x_ready = (i <= 15);
      tbl[i].x_page  = (i == 0) ? 4'd0 : (i <= 16 ? 4'(i - 1) : 4'd15);
      tbl[i].x_off   = (i != 0);
      tbl[i].x_b0    = tbl[i].x_page[2:0];
      tbl[i].x_b1    = {2'b00, tbl[i].x_page[3]};
      tbl[i].x_busy  = (i <= 17);
      tbl[i].x_done  = (i == 17);
    end
    clear_obs();
    for (int i = 0; i < 20; i++) begin
      cycle(0, tbl[i].start, tbl[i].frame, tbl[i].valid, tbl[i].data);
      chk($sformatf("tbl%0d_ready", i), bus.in_ready, tbl[i].x_ready);
      chk($sformatf("tbl%0d_we", i), bus.we, tbl[i].x_we);
      chk($sformatf("tbl%0d_page", i), bus.page_write_addr, tbl[i].x_page);
      chk($sformatf("tbl%0d_off", i), bus.write_addr_offset, tbl[i].x_off);
      chk($sformatf("tbl%0d_bank0", i), bus.lut_in_bank0, tbl[i].x_b0);
      chk($sformatf("tbl%0d_bank1", i), bus.lut_in_bank1, tbl[i].x_b1);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].x_busy);
      chk($sformatf("tbl%0d_done", i), load_done, tbl[i].x_done);
    end
    chk("tbl_we_count", cnt_we, 16);

    // Bubbled input
    run_load(0, 6'h11, 6'h22, 1'b1, "bubble");

    // Second start while busy (at write #5) must be ignored
    clear_obs();
    bad_off = 0;
    cycle(0, 1, 1, 0, 6'h00);
    budget = 0;
    while (cnt_done == 0 && budget < 200) begin
      cycle(0, (cnt_we == 5), (cnt_we == 5) ? 1'b0 : 1'b1, 1'b1, 6'($urandom));
      if (bus.we === 1'b1 && bus.write_addr_offset !== 1'b1) bad_off++;
      budget++;
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 6'h00);
    chk("busy_start_done_count", cnt_done, 1);
    chk("busy_start_we_count", cnt_we, 16);
    chk("busy_start_bad_offset", bad_off, 0);

    // Reset in the middle of a load, right after write #9
    clear_obs();
    cycle(0, 1, 0, 0, 6'h00);
    budget = 0;
    while (cnt_we < 9 && budget < 100) begin
      cycle(0, 0, 0, 1, 6'($urandom));
      budget++;
    end
    chk("midrst_reached_9", cnt_we, 9);
    cycle(1, 0, 0, 1, 6'h3F);
    chk("midrst_we", bus.we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", bus.in_ready, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 6'($urandom));
    chk("midrst_no_done", cnt_done, 0);
    run_load(1, 6'h05, 6'h2B, 1'b0, "restart");

    // Checksum values
`ifdef SYM_VN_LUT_LOADER_CKSUM_EN
    exp_ck = 6'h00;
`else
    exp_ck = 6'h00;
`endif
    run_load(0, 6'h3F, 6'h3F, 1'b0, "ck_all3f");
    chk("cksum_all_3f", ck_at_done, exp_ck);
`ifdef SYM_VN_LUT_LOADER_CKSUM_EN
    exp_ck = 6'h2A;
`else
    exp_ck = 6'h00;
`endif
    run_load(1, 6'h15, 6'h3F, 1'b0, "ck_first15");
    chk("cksum_first_15", ck_at_done, exp_ck);

    // Randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
            ($urandom_range(0, 3) != 0), 6'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sym_vn_lut_loader.md
Name: sym_vn_lut_loader

Overview:
- Write-side producer for the dual-bank symmetric VN IB LUT wrapper.
- Accepts a valid/ready stream of LUT entry pairs (bank0 and bank1 words) and writes one whole frame page set into both banks.
- Drives `we`, `page_write_addr`, `write_addr_offset`, `lut_in_bank0` and `lut_in_bank1`.
- Sits between the LUT-update source (host/ROM fetch) and the LUT wrapper. It lets the decoder read one frame slot while the other slot is reloaded.

Parameters:
- QUAN_SIZE, 3, bit width of one LUT entry.
- ENTRY_ADDR, 5, total LUT address width (frame offset plus page address).
- MULTI_FRAME_NUM, 2, number of frame slots. PAGE_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM) = 4, so one load is 16 pages.

Ports:
- write_clk  input  1  sole clock. The LUT wrapper samples writes on the same edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a frame load. Sampled only in IDLE.
- load_frame  input  $clog2(MULTI_FRAME_NUM)  target frame slot. Latched with load_start.
- in_valid  input  1  upstream entry valid.
- in_data  input  2*QUAN_SIZE  entry pair: [QUAN_SIZE-1:0] goes to bank0, upper half goes to bank1.
- in_ready  output  1  loader accepts in_data this cycle.
- we  output  1  LUT write enable.
- page_write_addr  output  PAGE_W  LUT page write address.
- write_addr_offset  output  $clog2(MULTI_FRAME_NUM)  LUT frame offset.
- lut_in_bank0  output  QUAN_SIZE  bank0 write data.
- lut_in_bank1  output  QUAN_SIZE  bank1 write data.
- busy  output  1  high from the cycle after start acceptance through the DONE state.
- load_done  output  1  one-cycle pulse when the last entry has been written.
- cksum  output  2*QUAN_SIZE  load checksum. Meaningful only with the optional feature.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; page counter 0; latched frame 0.
  - Reset in the middle of a load abandons it. The partially written frame is undefined and load_done is not pulsed.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD when load_start = 1. In that cycle: latch load_frame and clear the counter. load_start in any other state is ignored.
  - LOAD:
    - in_ready = 1 while the counter has not yet issued entry 2^PAGE_W-1.
    - Each handshake (in_valid & in_ready) registers the outputs for the next cycle:
      - we = 1
      - page_write_addr = counter
      - write_addr_offset = latched frame
      - lut_in_bank0 / lut_in_bank1 = halves of in_data
    - The counter then increments.
    - No handshake: we = 0 next cycle; address and data hold their last values.
    - Write latency is exactly 1 cycle from handshake to we.
  - LOAD -> DONE on the handshake with counter = 2^PAGE_W-1. in_ready drops in the same following cycle in which the final we is high.
  - DONE: load_done = 1 and we = 0 for exactly one cycle, then -> IDLE. Counter wraps to 0.
- Entries are written strictly in ascending page order 0..2^PAGE_W-1. Bubbles on in_valid only stretch the load.
- in_ready is 0 in IDLE and DONE. in_valid there is ignored and no data is consumed.
- A load_frame value >= MULTI_FRAME_NUM is masked to its low bits (no error).

Optional Feature:
- Macro: SYM_VN_LUT_LOADER_CKSUM_EN.
- Defined:
  - cksum is cleared on load_start acceptance.
  - It XOR-accumulates every accepted in_data word.
  - It is stable and valid from the load_done cycle until the next accepted load_start.
- Undefined: cksum is tied to 0 and no accumulator logic is built.

Decomposition:
- Shared package/header: PAGE_W and FRAME_W derivations, FSM state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2), entry-pair field offsets.
- One natural sub-module: sym_vn_lut_wr_cnt, the page counter with clear, increment, and terminal-count flag.
- FSM and output registers stay in the top.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then in_valid=1 with no start -> in_ready, we, busy and load_done all 0 indefinitely.
- Full back-to-back load:
  - Stimulus: load_start, load_frame=1, in_valid=1 continuously, in_data = k for k = 0..15.
  - Response: 16 consecutive we pulses, page_write_addr 0..15, write_addr_offset=1, lut_in_bank0 = k[2:0], lut_in_bank1 = k[5:3].
  - Then load_done in the cycle after the last we, and busy low the cycle after that.
- Bubbled input: in_valid toggling 1/0 -> we toggles 1/0 with the same pattern, delayed by one cycle. Addresses stay contiguous and the total is 16 writes.
- Start ignored while busy: second load_start with load_frame=0 at write #5 -> offset remains 1 throughout and only one load_done occurs.
- Reset mid-load: rst at write #9 -> next cycle we=0, busy=0, in_ready=0. No load_done. A new load restarts at page 0.
- Checksum (macro defined): in_data = 6'h3F for all 16 entries -> cksum = 6'h00 at load_done. Same run with entry 0 = 6'h15 -> cksum = 6'h2A.
